// File: rtl/ddr_cdc_word_sender.sv
// ----------------------------------------------------------------------------
// ddr_cdc_word_sender
//
// Source-domain end of a 2-phase (toggle) request/acknowledge handshake that
// carries one DATA_WIDTH word per transfer into another clock domain.
//
// A word accepted in IDLE is registered onto o_data_out first. One cycle
// later (LAUNCH) o_req_out toggles, so the data bus is already stable when
// the destination sees the request. The block then waits (WAIT_ACK) until
// the synchronised acknowledge toggle matches o_req_out, and returns to IDLE.
//
// Ports:
//   i_clk            source-domain clock
//   i_rst            synchronous reset, active-high
//   i_data_in        word to send
//   i_data_valid     i_data_in valid this cycle
//   o_ready          block accepts a word this cycle (state is IDLE)
//   o_data_out       registered word, stable while the request is outstanding
//   o_req_out        request toggle towards the destination domain
//   i_ack_in         acknowledge toggle from the destination (asynchronous)
//   o_drop_count     saturating count of cycles with valid while not ready
//   o_timeout        sticky: a WAIT_ACK lasted longer than TIMEOUT_CYCLES
//   o_spurious_ack   sticky: synchronised ack toggled outside WAIT_ACK
// ----------------------------------------------------------------------------
module ddr_cdc_word_sender #(
  parameter int DATA_WIDTH     = 24,
  parameter int SYNC_STAGES    = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_data_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_req_out,
  input  logic                  i_ack_in,
  output logic [15:0]           o_drop_count,
  output logic                  o_timeout,
  output logic                  o_spurious_ack
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAUNCH   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  // The timeout counter only needs to reach TIMEOUT_CYCLES; a disabled
  // timeout still gets a 1-bit counter so the declarations stay legal.
  localparam int              CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_dataOut;
  logic                  r_reqOut;
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [SYNC_STAGES-1:0] r_ackSync;
  logic                  r_ackPrev;
  logic [15:0]           r_dropCount;
  logic                  r_timeout;
  logic                  r_spurious;
  logic [CNT_W-1:0]      r_toCount;

  logic                  w_ackS;
  logic                  w_ready;

  // Last synchroniser stage is the only copy of the ack that logic may use.
  assign w_ackS  = r_ackSync[SYNC_STAGES-1];
  assign w_ready = (r_state == ST_IDLE);

  assign o_ready        = w_ready;
  assign o_data_out     = r_dataOut;
  assign o_req_out      = r_reqOut;
  assign o_drop_count   = r_dropCount;
  assign o_timeout      = r_timeout;
  assign o_spurious_ack = r_spurious;

  // Handshake state machine, ack synchroniser and status flags.
  // The ack chain shifts every cycle regardless of state; r_ackPrev keeps the
  // previous synchronised value so any ack edge can be seen, which is how an
  // ack toggle arriving while nothing is outstanding gets flagged.
  // In WAIT_ACK the timeout counter stops at TIMEOUT_CYCLES and the flag is
  // raised on the following waiting cycle; the transfer itself keeps waiting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_dataOut   <= '0;
      r_reqOut    <= 1'b0;
      r_ackSync   <= '0;
      r_ackPrev   <= 1'b0;
      r_dropCount <= 16'd0;
      r_timeout   <= 1'b0;
      r_spurious  <= 1'b0;
      r_toCount   <= '0;
    end else begin
      r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], i_ack_in};
      r_ackPrev <= w_ackS;

      if (i_data_valid && !w_ready && (r_dropCount != 16'hFFFF)) begin
        r_dropCount <= r_dropCount + 16'd1;
      end

      if ((w_ackS != r_ackPrev) && ((r_state == ST_IDLE) || (r_state == ST_LAUNCH))) begin
        r_spurious <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_data_valid) begin
            r_dataOut <= i_data_in;
            r_state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_reqOut  <= ~r_reqOut;
          r_toCount <= '0;
          r_state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (w_ackS == r_reqOut) begin
            r_state <= ST_IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (r_toCount == TIMEOUT_VAL) begin
              r_timeout <= 1'b1;
            end else begin
              r_toCount <= r_toCount + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cdc_word_sender.sv
// ----------------------------------------------------------------------------
// tb_ddr_cdc_word_sender
//
// Self-checking bench for ddr_cdc_word_sender. Words handed to the DUT are
// pushed into an expected-word queue; a monitor pops one each time the request
// toggles and compares the data bus. A behavioural responder plays the
// destination domain by echoing the request toggle after a programmable delay.
// Inputs change on the falling clock edge; outputs are read away from the
// rising edge.
// ----------------------------------------------------------------------------
module tb_ddr_cdc_word_sender;

  localparam int DW   = 24;
  localparam int SYNC = 4;
  localparam int TO   = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] dataIn = '0;
  logic          dataValid = 1'b0;
  logic          ackIn = 1'b0;
  logic          ready;
  logic [DW-1:0] dataOut;
  logic          reqOut;
  logic [15:0]   dropCount;
  logic          timeoutFlag;
  logic          spuriousAck;

  int            checkCount = 0;
  int            passCount = 0;
  logic [DW-1:0] expQ[$];
  logic          modelReq = 1'b0;
  int            modelDrops = 0;
  int            toggleCount = 0;
  logic          prevReq = 1'b0;
  logic          autoAck = 1'b0;
  int            ackDelay = 7;
  int            toggleBase;

  always #5 clk = ~clk;

  ddr_cdc_word_sender #(
    .DATA_WIDTH(DW),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_data_in(dataIn),
    .i_data_valid(dataValid),
    .o_ready(ready),
    .o_data_out(dataOut),
    .o_req_out(reqOut),
    .i_ack_in(ackIn),
    .o_drop_count(dropCount),
    .o_timeout(timeoutFlag),
    .o_spurious_ack(spuriousAck)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Offer a word with valid held high until the block is idle, then record
  // it as the next word the destination must see. Valid stays high on return
  // so consecutive calls give back-to-back traffic.
  task automatic applyStimulus(input logic [DW-1:0] word, input int budget);
    bit taken = 1'b0;
    dataIn    = word;
    dataValid = 1'b1;
    for (int c = 0; c < budget && !taken; c++) begin
      if (ready) begin
        expQ.push_back(word);
        modelReq = ~modelReq;
        taken = 1'b1;
      end
      @(negedge clk);
    end
    if (!taken) checkOutput("accept_timeout", 32'(taken), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    while (!ready && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("idle_reached", 32'(ready), 32'd1);
  endtask

  // Drop reference: any cycle presenting valid while the block is busy is one
  // dropped word, saturating at 16 bits; sampled just before the rising edge.
  always begin
    @(negedge clk);
    #4;
    if (rst) modelDrops = 0;
    else if (dataValid && !ready && modelDrops < 65535) modelDrops++;
  end

  // Scoreboard monitor: every request toggle must carry the oldest word that
  // was handed over, and the request level must match the number of words sent.
  always @(negedge clk) begin
    if (rst) begin
      prevReq = reqOut;
    end else if (reqOut !== prevReq) begin
      toggleCount++;
      checkOutput("req_level", 32'(reqOut), 32'(modelReq));
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_req: actual=toggle required=no_toggle");
      end else begin
        checkOutput("sb_data", 32'(dataOut), 32'(expQ.pop_front()));
      end
      prevReq = reqOut;
    end
  end

  // Destination-domain responder: echoes the request toggle after ackDelay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (autoAck && !rst && (reqOut !== ackIn)) begin
        repeat (ackDelay) @(negedge clk);
        if (autoAck && !rst) ackIn = reqOut;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence, then randomized traffic, then the corner cases.
  initial begin
    // Reset held for three edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_ready",    32'(ready),       32'd1);
    checkOutput("rst_req",      32'(reqOut),      32'd0);
    checkOutput("rst_data",     32'(dataOut),     32'd0);
    checkOutput("rst_drop",     32'(dropCount),   32'd0);
    checkOutput("rst_timeout",  32'(timeoutFlag), 32'd0);
    checkOutput("rst_spurious", 32'(spuriousAck), 32'd0);

    // Single word with exact latencies
    dataIn = 24'hA5C3F0;
    dataValid = 1'b1;
    expQ.push_back(24'hA5C3F0);
    modelReq = ~modelReq;
    @(posedge clk);
    #1;
    dataValid = 1'b0;
    checkOutput("single_data_n",  32'(dataOut), 32'hA5C3F0);
    checkOutput("single_req_n",   32'(reqOut),  32'd0);
    checkOutput("single_ready_n", 32'(ready),   32'd0);
    @(posedge clk);
    #1;
    checkOutput("single_req_n1",  32'(reqOut),  32'd1);
    checkOutput("single_data_n1", 32'(dataOut), 32'hA5C3F0);
    @(negedge clk);
    ackIn = 1'b1;
    for (int i = 0; i <= SYNC; i++) begin
      @(posedge clk);
      #1;
      if (i == SYNC - 1) checkOutput("single_ready_early", 32'(ready), 32'd0);
      if (i == SYNC)     checkOutput("single_ready_k_s",   32'(ready), 32'd1);
    end
    @(negedge clk);

    // Back-to-back words 1..5, valid held, ack after 7 cycles
    toggleBase = toggleCount;
    autoAck = 1'b1;
    ackDelay = 7;
    for (int w = 1; w <= 5; w++) applyStimulus(DW'(w), 100);
    dataValid = 1'b0;
    waitIdle(100);
    checkOutput("b2b_toggles", 32'(toggleCount - toggleBase), 32'd5);
    checkOutput("b2b_drops",   32'(dropCount),  32'(modelDrops));

    // Randomized words, ack delays and idle gaps
    for (int n = 0; n < 20; n++) begin
      ackDelay = int'($urandom_range(1, 12));
      applyStimulus(DW'($urandom), 200);
      if ($urandom_range(0, 1) == 1) begin
        dataValid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    dataValid = 1'b0;
    waitIdle(100);
    checkOutput("rand_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("rand_drops",    32'(dropCount),   32'(modelDrops));
    checkOutput("rand_timeout",  32'(timeoutFlag), 32'd0);
    checkOutput("rand_spurious", 32'(spuriousAck), 32'd0);

    // Stalled transfer: timeout and drop-counter saturation
    autoAck = 1'b0;
    applyStimulus(DW'($urandom), 50);
    repeat (90) @(negedge clk);
    checkOutput("timeout_early", 32'(timeoutFlag), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("timeout_set",   32'(timeoutFlag), 32'd1);
    repeat (70000) @(negedge clk);
    checkOutput("drop_sat",       32'(dropCount), 32'hFFFF);
    checkOutput("drop_sat_model", 32'(dropCount), 32'(modelDrops));
    dataValid = 1'b0;
    ackIn = modelReq;
    waitIdle(SYNC + 10);
    checkOutput("timeout_sticky", 32'(timeoutFlag), 32'd1);

    // Ack toggle while idle
    ackIn = ~ackIn;
    repeat (SYNC - 1) @(negedge clk);
    checkOutput("spurious_early", 32'(spuriousAck), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("spurious_set",   32'(spuriousAck), 32'd1);
    checkOutput("spurious_ready", 32'(ready),       32'd1);
    checkOutput("spurious_req",   32'(reqOut),      32'(modelReq));
    ackIn = ~ackIn;
    repeat (SYNC + 3) @(negedge clk);

    // Reset in the middle of a transfer with the request high
    if (modelReq) begin
      autoAck = 1'b1;
      ackDelay = 3;
      applyStimulus(24'h0F0F0F, 50);
      dataValid = 1'b0;
      waitIdle(50);
    end
    autoAck = 1'b0;
    applyStimulus(24'h5A5A5A, 50);
    dataValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_req_before", 32'(reqOut), 32'd1);
    rst = 1'b1;
    ackIn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReq = 1'b0;
    checkOutput("midrst_req",      32'(reqOut),      32'd0);
    checkOutput("midrst_ready",    32'(ready),       32'd1);
    checkOutput("midrst_data",     32'(dataOut),     32'd0);
    checkOutput("midrst_timeout",  32'(timeoutFlag), 32'd0);
    checkOutput("midrst_spurious", 32'(spuriousAck), 32'd0);
    checkOutput("midrst_sb_empty", 32'(expQ.size()), 32'd0);
    expQ.delete();
    autoAck = 1'b1;
    ackDelay = 5;
    applyStimulus(24'h13579B, 50);
    dataValid = 1'b0;
    waitIdle(50);
    checkOutput("post_rst_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("post_rst_drops",    32'(dropCount),   32'(modelDrops));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
